// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a combinational instruction memory
// and hands instructions to decode through a single-entry IF/ID register.
module fetch_stage #(
  parameter int                XLEN                   = 64,
  parameter int                INSTRUCTION_LENGTH     = XLEN / 2,
  parameter int                SIMULATION_MEMORY_SIZE = 6,
  parameter logic [XLEN-1:0]   RESET_PC               = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [SIMULATION_MEMORY_SIZE-2:0] imem_addr,
  input  logic [INSTRUCTION_LENGTH-1:0]     imem_instruction,
  output logic                              id_valid,
  input  logic                              id_ready,
  output logic [INSTRUCTION_LENGTH-1:0]     id_instr,
  output logic [XLEN-1:0]                   id_pc,
  input  logic                              redirect_valid,
  input  logic [XLEN-1:0]                   redirect_pc,
  input  logic                              fence_done,
  output logic                              fetch_fault,
  output logic [XLEN-1:0]                   fault_pc
);

  typedef enum logic [1:0] {
    RUN,
    FENCE_WAIT,
    FAULT
  } state_t;

  state_t                        r_state;
  logic [XLEN-1:0]               r_pc;
  logic                          r_idValid;
  logic [INSTRUCTION_LENGTH-1:0] r_idInstr;
  logic [XLEN-1:0]               r_idPc;
  logic                          r_fetchFault;
  logic [XLEN-1:0]               r_faultPc;

  logic w_load;
  logic w_isFence;
  logic w_redirectAligned;

  // The word address simply drops the byte offset, so it wraps with memory depth.
  assign imem_addr = r_pc[SIMULATION_MEMORY_SIZE:2];

  assign w_load            = (r_state == RUN) && (!r_idValid || id_ready) && !redirect_valid;
  assign w_isFence         = (imem_instruction[6:0] == 7'b0001111);
  assign w_redirectAligned = (redirect_pc[1:0] == 2'b00);

  // Redirect outranks everything but reset; a FENCE stalls loads until fence_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_pc         <= RESET_PC;
      r_idValid    <= 1'b0;
      r_idInstr    <= '0;
      r_idPc       <= '0;
      r_fetchFault <= 1'b0;
      r_faultPc    <= '0;
    end else if (redirect_valid) begin
      r_idValid <= 1'b0;
      if (w_redirectAligned) begin
        r_pc         <= redirect_pc;
        r_state      <= RUN;
        r_fetchFault <= 1'b0;
      end else begin
        r_state      <= FAULT;
        r_fetchFault <= 1'b1;
        r_faultPc    <= redirect_pc;
      end
    end else begin
      if (w_load) begin
        r_idInstr <= imem_instruction;
        r_idPc    <= r_pc;
        r_idValid <= 1'b1;
        r_pc      <= r_pc + XLEN'(4);
        if (w_isFence) begin
          r_state <= FENCE_WAIT;
        end
      end else if (id_ready) begin
        r_idValid <= 1'b0;
      end
      if ((r_state == FENCE_WAIT) && fence_done) begin
        r_state <= RUN;
      end
    end
  end

  assign id_valid    = r_idValid;
  assign id_instr    = r_idInstr;
  assign id_pc       = r_idPc;
  assign fetch_fault = r_fetchFault;
  assign fault_pc    = r_faultPc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a 32-word combinational memory model feeds the
// DUT and every expected IF/ID value is written out by hand.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [4:0]  imemAddr;
  logic [31:0] imemInstruction;
  logic        idValid;
  logic        idReady;
  logic [31:0] idInstr;
  logic [63:0] idPc;
  logic        redirectValid;
  logic [63:0] redirectPc;
  logic        fenceDone;
  logic        fetchFault;
  logic [63:0] faultPc;

  logic [31:0] mem [32];

  int compared = 0;
  int mismatched = 0;

  fetch_stage #(
    .XLEN(64),
    .INSTRUCTION_LENGTH(32),
    .SIMULATION_MEMORY_SIZE(6),
    .RESET_PC(64'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imemAddr),
    .imem_instruction(imemInstruction),
    .id_valid(idValid),
    .id_ready(idReady),
    .id_instr(idInstr),
    .id_pc(idPc),
    .redirect_valid(redirectValid),
    .redirect_pc(redirectPc),
    .fence_done(fenceDone),
    .fetch_fault(fetchFault),
    .fault_pc(faultPc)
  );

  assign imemInstruction = mem[imemAddr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs, then step to the following falling edge to sample.
  task automatic applyStimulus(input logic rstV, input logic readyV, input logic redirV,
                               input logic [63:0] redirPcV, input logic fenceDoneV);
    rst           = rstV;
    idReady       = readyV;
    redirectValid = redirV;
    redirectPc    = redirPcV;
    fenceDone     = fenceDoneV;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkEntry(input string tag, input logic [63:0] pcExp,
                            input logic [31:0] instrExp);
    checkOutput({tag, ".valid"}, {63'b0, idValid}, 64'h1);
    checkOutput({tag, ".pc"}, idPc, pcExp);
    checkOutput({tag, ".instr"}, {32'b0, idInstr}, {32'b0, instrExp});
  endtask

  task automatic loadProgram();
    for (int i = 0; i < 32; i++) mem[i] = 32'h00000013 | (32'(i) << 7);
    mem[0] = 32'h00100093;
    mem[1] = 32'h00200113;
    mem[2] = 32'h00300193;
    mem[3] = 32'h00400213;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] seqPc [4];
    seqPc = '{64'h0, 64'h4, 64'h8, 64'hC};
    loadProgram();

    // Reset state and in-order streaming
    doReset();
    checkOutput("rst.valid", {63'b0, idValid}, 64'h0);
    checkOutput("rst.pc", idPc, 64'h0);
    checkOutput("rst.instr", {32'b0, idInstr}, 64'h0);
    checkOutput("rst.fault", {63'b0, fetchFault}, 64'h0);
    checkOutput("rst.faultPc", faultPc, 64'h0);
    checkOutput("rst.addr", {59'b0, imemAddr}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
      checkEntry($sformatf("stream%0d", i), seqPc[i], mem[i]);
    end

    // Backpressure holds entry 0x4 and the fetch address
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkEntry("bp.pre", 64'h4, 32'h00200113);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
      checkEntry($sformatf("bp.hold%0d", i), 64'h4, 32'h00200113);
      checkOutput("bp.addr", {59'b0, imemAddr}, 64'h2);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkEntry("bp.next", 64'h8, 32'h00300193);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkEntry("bp.after", 64'hC, 32'h00400213);

    // FENCE at 0x4 stalls until fence_done
    mem[1] = 32'h0FF0000F;
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkEntry("fence.issue", 64'h4, 32'h0FF0000F);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput($sformatf("fence.wait%0d", i), {63'b0, idValid}, 64'h0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
    checkOutput("fence.doneCycle", {63'b0, idValid}, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkEntry("fence.resume", 64'h8, 32'h00300193);

    // Redirect during FENCE_WAIT cancels the wait
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("fredir.waiting", {63'b0, idValid}, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h40, 1'b0);
    checkOutput("fredir.flush", {63'b0, idValid}, 64'h0);
    checkOutput("fredir.addr", {59'b0, imemAddr}, 64'h10);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkEntry("fredir.fetch", 64'h40, mem[16]);
    loadProgram();

    // Redirect flushes a valid entry even with decode ready
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkEntry("redir.pre", 64'hC, 32'h00400213);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h40, 1'b0);
    checkOutput("redir.flush", {63'b0, idValid}, 64'h0);
    checkOutput("redir.addr", {59'b0, imemAddr}, 64'h10);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkEntry("redir.fetch", 64'h40, mem[16]);

    // Misaligned redirect faults; an aligned one recovers
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h42, 1'b0);
    checkOutput("fault.flag", {63'b0, fetchFault}, 64'h1);
    checkOutput("fault.pc", faultPc, 64'h42);
    checkOutput("fault.valid", {63'b0, idValid}, 64'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput($sformatf("fault.stall%0d", i), {63'b0, idValid}, 64'h0);
      checkOutput("fault.hold", {63'b0, fetchFault}, 64'h1);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h10, 1'b0);
    checkOutput("fault.clear", {63'b0, fetchFault}, 64'h0);
    checkOutput("fault.addr", {59'b0, imemAddr}, 64'h4);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkEntry("fault.fetch", 64'h10, mem[4]);

    // Word address wraps while the PC keeps counting
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h78, 1'b0);
    checkOutput("wrap.addr0", {59'b0, imemAddr}, 64'd30);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkEntry("wrap.e0", 64'h78, mem[30]);
    checkOutput("wrap.addr1", {59'b0, imemAddr}, 64'd31);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkEntry("wrap.e1", 64'h7C, mem[31]);
    checkOutput("wrap.addr2", {59'b0, imemAddr}, 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkEntry("wrap.e2", 64'h80, 32'h00100093);

    // Mid-stream reset discards the entry and a latched fault
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h43, 1'b0);
    checkOutput("pre.rst.fault", {63'b0, fetchFault}, 64'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("mrst.valid", {63'b0, idValid}, 64'h0);
    checkOutput("mrst.pc", idPc, 64'h0);
    checkOutput("mrst.instr", {32'b0, idInstr}, 64'h0);
    checkOutput("mrst.fault", {63'b0, fetchFault}, 64'h0);
    checkOutput("mrst.faultPc", faultPc, 64'h0);
    checkOutput("mrst.addr", {59'b0, imemAddr}, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkEntry("mrst.first", 64'h0, 32'h00100093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
